lsu_mem: RTL and testbench
==========================

LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- rd_wr_en_i / rd_wr_sel_i / rd_wr_addr_i  in  1/2/5  writeback control from execute.
- dram_rd_en_i  in  1  load request.
- dram_wr_en_i  in  1  store request.
- dram_rd_sel_i  in  3  ram_op_enum load type.
- dram_wr_sel_i  in  2  store type: byte, half, word.
- addr_i  in  XLEN  effective address.
- wr_data_i  in  XLEN  store data.
- bus_req_o / bus_we_o  out  1/1  bus request, write strobe.
- bus_addr_o  out  XLEN  word-aligned address.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  XLEN  lane-replicated store data.
- bus_ack_i  in  1  one-cycle completion.
- bus_rdata_i  in  XLEN  read word, valid with ack.
- stall_o  out  1  holds upstream pipeline.
- rd_wr_en_r_o / rd_wr_sel_r_o / rd_wr_addr_r_o / dram_rd_sel_r_o  out  1/2/5/3  registered control to writeback.
- dram_rd_data_o  out  XLEN  registered load word, addressed lane shifted to bit 0.
- misalign_o  out  1  one-cycle misaligned-access pulse.

Function
REQ-003 SHALL implement FSM IDLE, BUSY.
REQ-004 IDLE: dram_rd_en_i or dram_wr_en_i SHALL latch request, assert bus_req_o same cycle (combinational from inputs), move to BUSY unless bus_ack_i is already high.
REQ-005 BUSY: SHALL hold bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o stable until bus_ack_i, then return to IDLE.
REQ-006 stall_o SHALL be (IDLE and request and not bus_ack_i) or (BUSY and not bus_ack_i).
REQ-007 _r outputs SHALL load from inputs on every edge with stall_o low; hold while stall_o high.
REQ-008 On ack of a load, dram_rd_data_o SHALL be bus_rdata_i >> (8*addr[1:0]), registered same edge; otherwise hold.
REQ-009 Both dram_rd_en_i and dram_wr_en_i high SHALL be treated as a store.
REQ-010 Stores: byte be=0001<<addr[1:0], data replicated x4; half be=0011<<(2*addr[1]), data replicated x2; word be=1111.
REQ-011 bus_addr_o SHALL be {addr[XLEN-1:2],2'b00}; bus_req_o low in IDLE with no request.
REQ-012 No-request cycles SHALL take 1-cycle latency; loads/stores SHALL take 1 + ack wait cycles.
REQ-013 While stall_o high, _r outputs SHALL hold last values; rd_wr_en_r_o not re-issued.

Reset
REQ-014 rst_i SHALL immediately force IDLE, bus_req_o=0, stall_o=0, misalign_o=0, all _r outputs and dram_rd_data_o to 0.
REQ-015 Reset mid-BUSY SHALL abandon transaction; late bus_ack_i after reset SHALL be ignored.

Configuration
REQ-016 Macro LSU_MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no bus request, pulse misalign_o one cycle, set rd_wr_en_r_o=0.
REQ-017 Macro undefined: misalign_o SHALL tie 0; offending low address bits SHALL be masked (half addr[0], word addr[1:0]) before lane and be computation.

Verification
REQ-018 Bench SHALL cover:
- LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stall 3 cycles, bus_be_o=1111, dram_rd_data_o=0xDEADBEEF.
- LB addr 0x103, rdata 0x80112233, ack same cycle -> no stall, dram_rd_data_o[7:0]=0x80, dram_rd_sel_r_o=DRAM_RD_B.
- SH addr 0x102, data 0x0000ABCD -> bus_be_o=1100, bus_wdata_o=0xABCDABCD, bus_addr_o=0x100.
- rst_i pulsed in BUSY -> bus_req_o=0 same cycle, later ack has no effect.
- LSU_MISALIGN_TRAP_EN, LW addr 0x101 -> misalign_o one cycle, bus_req_o never high.
- ALU op rd=5 -> rd_wr_en_r_o=1, rd_wr_addr_r_o=5 next edge.

Source files
------------

// File: rtl/lsu_mem.sv
// lsu_mem -- load/store unit memory stage.
//
// Turns load/store requests from execute into single-beat bus transactions,
// stalls the pipeline while a transaction waits for bus_ack_i, registers the
// writeback control, and returns the addressed load lane at bit 0.
//
// Build option: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses issue no bus request, pulse
//               misalign_o for one cycle and suppress the register write.
//   undefined - misalign_o is tied low; the offending low address bits are
//               masked before the lane/byte-enable computation.
//
// Ports
//   clk_i, rst_i                     clock, async active-high reset
//   rd_wr_en_i/sel_i/addr_i          writeback control from execute
//   dram_rd_en_i, dram_wr_en_i       load / store request (both = store)
//   dram_rd_sel_i                    load type (DRAM_RD_*)
//   dram_wr_sel_i                    store type (0 byte, 1 half, 2 word)
//   addr_i, wr_data_i                effective address, store data
//   bus_req_o/we_o/addr_o/be_o/wdata_o  bus request side
//   bus_ack_i, bus_rdata_i           one-cycle completion, read word
//   stall_o                          holds the upstream pipeline
//   *_r_o                            registered control to writeback
//   dram_rd_data_o                   registered load word, lane at bit 0
//   misalign_o                       one-cycle misaligned-access pulse

module lsu_mem #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            rd_wr_en_i,
   input  logic [1:0]      rd_wr_sel_i,
   input  logic [4:0]      rd_wr_addr_i,
   input  logic            dram_rd_en_i,
   input  logic            dram_wr_en_i,
   input  logic [2:0]      dram_rd_sel_i,
   input  logic [1:0]      dram_wr_sel_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wr_data_i,
   output logic            bus_req_o,
   output logic            bus_we_o,
   output logic [XLEN-1:0] bus_addr_o,
   output logic [3:0]      bus_be_o,
   output logic [XLEN-1:0] bus_wdata_o,
   input  logic            bus_ack_i,
   input  logic [XLEN-1:0] bus_rdata_i,
   output logic            stall_o,
   output logic            rd_wr_en_r_o,
   output logic [1:0]      rd_wr_sel_r_o,
   output logic [4:0]      rd_wr_addr_r_o,
   output logic [2:0]      dram_rd_sel_r_o,
   output logic [XLEN-1:0] dram_rd_data_o,
   output logic            misalign_o
);

   // ram_op_enum load types
   localparam logic [2:0] DRAM_RD_B  = 3'd0;
   localparam logic [2:0] DRAM_RD_H  = 3'd1;
   localparam logic [2:0] DRAM_RD_W  = 3'd2;
   localparam logic [2:0] DRAM_RD_BU = 3'd3;
   localparam logic [2:0] DRAM_RD_HU = 3'd4;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              we_q;
   logic [XLEN-1:0]   addr_q;
   logic [3:0]        be_q;
   logic [XLEN-1:0]   wdata_q;
   logic              ld_q;
   logic [1:0]        off_q;

   logic              req, is_st, misal_raw, misal, issue, idle, busy;
   logic [1:0]        size, off;
   logic [3:0]        be_c;
   logic [XLEN-1:0]   wdata_c, addr_c;

   assign req   = dram_rd_en_i | dram_wr_en_i;
   assign is_st = dram_wr_en_i;
   assign idle  = (state_q == IDLE);
   assign busy  = (state_q == BUSY);

   always_comb begin
      size = SZ_W;
      if (is_st) begin
         case (dram_wr_sel_i)
            2'd0:    size = SZ_B;
            2'd1:    size = SZ_H;
            default: size = SZ_W;
         endcase
      end else begin
         case (dram_rd_sel_i)
            DRAM_RD_B, DRAM_RD_BU: size = SZ_B;
            DRAM_RD_H, DRAM_RD_HU: size = SZ_H;
            default:               size = SZ_W;
         endcase
      end
   end

   assign misal_raw = ((size == SZ_H) && addr_i[0]) ||
                      ((size == SZ_W) && (addr_i[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
   assign misal = req & misal_raw;
   assign off   = addr_i[1:0];
`else
   // Without the trap, misalignment is resolved by dropping the low bits
   // the access size cannot use.
   logic unused_misal;
   assign unused_misal = misal_raw;
   assign misal = 1'b0;
   assign off   = (size == SZ_W) ? 2'b00 :
                  (size == SZ_H) ? {addr_i[1], 1'b0} : addr_i[1:0];
`endif

   assign issue = idle & req & ~misal;

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = wr_data_i;
      case (size)
         SZ_B: begin
            be_c    = 4'b0001 << off;
            wdata_c = {(XLEN/8){wr_data_i[7:0]}};
         end
         SZ_H: begin
            be_c    = 4'b0011 << off;
            wdata_c = {(XLEN/16){wr_data_i[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = wr_data_i;
         end
      endcase
   end

   assign addr_c = {addr_i[XLEN-1:2], 2'b00};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (issue && !bus_ack_i) state_d = BUSY;
         BUSY:    if (bus_ack_i)           state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   // In IDLE the bus is driven straight from the request so a same-cycle ack
   // completes with no stall; in BUSY it replays the latched request.
   assign bus_req_o   = ~rst_i & (issue | busy);
   assign bus_we_o    = busy ? we_q    : is_st;
   assign bus_addr_o  = busy ? addr_q  : addr_c;
   assign bus_be_o    = busy ? be_q    : be_c;
   assign bus_wdata_o = busy ? wdata_q : wdata_c;
   assign stall_o     = ~rst_i & ((issue | busy) & ~bus_ack_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         we_q            <= 1'b0;
         addr_q          <= '0;
         be_q            <= 4'b0000;
         wdata_q         <= '0;
         ld_q            <= 1'b0;
         off_q           <= 2'b00;
         rd_wr_en_r_o    <= 1'b0;
         rd_wr_sel_r_o   <= 2'b00;
         rd_wr_addr_r_o  <= 5'd0;
         dram_rd_sel_r_o <= 3'd0;
         dram_rd_data_o  <= '0;
         misalign_o      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (issue) begin
            we_q    <= is_st;
            addr_q  <= addr_c;
            be_q    <= be_c;
            wdata_q <= wdata_c;
            ld_q    <= ~is_st;
            off_q   <= off;
            if (bus_ack_i && !is_st)
               dram_rd_data_o <= bus_rdata_i >> {off, 3'b000};
         end else if (busy && bus_ack_i && ld_q) begin
            dram_rd_data_o <= bus_rdata_i >> {off_q, 3'b000};
         end
         if (!stall_o) begin
            rd_wr_en_r_o    <= rd_wr_en_i & ~misal;
            rd_wr_sel_r_o   <= rd_wr_sel_i;
            rd_wr_addr_r_o  <= rd_wr_addr_i;
            dram_rd_sel_r_o <= dram_rd_sel_i;
         end
         misalign_o <= idle & misal;
      end
   end

endmodule

// File: tb/tb_lsu_mem.sv
module tb_lsu_mem;

   localparam logic [2:0] DRAM_RD_B = 3'd0;
   localparam logic [2:0] DRAM_RD_H = 3'd1;
   localparam logic [2:0] DRAM_RD_W = 3'd2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rd_wr_en_i;
   logic [1:0]  rd_wr_sel_i;
   logic [4:0]  rd_wr_addr_i;
   logic        dram_rd_en_i, dram_wr_en_i;
   logic [2:0]  dram_rd_sel_i;
   logic [1:0]  dram_wr_sel_i;
   logic [31:0] addr_i, wr_data_i;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;
   logic        stall_o;
   logic        rd_wr_en_r_o;
   logic [1:0]  rd_wr_sel_r_o;
   logic [4:0]  rd_wr_addr_r_o;
   logic [2:0]  dram_rd_sel_r_o;
   logic [31:0] dram_rd_data_o;
   logic        misalign_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;
   int stall_cnt;

   always #5 clk_i = ~clk_i;

   lsu_mem #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_wr_en_i(rd_wr_en_i), .rd_wr_sel_i(rd_wr_sel_i), .rd_wr_addr_i(rd_wr_addr_i),
      .dram_rd_en_i(dram_rd_en_i), .dram_wr_en_i(dram_wr_en_i),
      .dram_rd_sel_i(dram_rd_sel_i), .dram_wr_sel_i(dram_wr_sel_i),
      .addr_i(addr_i), .wr_data_i(wr_data_i),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
      .stall_o(stall_o),
      .rd_wr_en_r_o(rd_wr_en_r_o), .rd_wr_sel_r_o(rd_wr_sel_r_o),
      .rd_wr_addr_r_o(rd_wr_addr_r_o), .dram_rd_sel_r_o(dram_rd_sel_r_o),
      .dram_rd_data_o(dram_rd_data_o), .misalign_o(misalign_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_in();
      rd_wr_en_i = 0; rd_wr_sel_i = 0; rd_wr_addr_i = 0;
      dram_rd_en_i = 0; dram_wr_en_i = 0;
      dram_rd_sel_i = 0; dram_wr_sel_i = 0;
      addr_i = 0; wr_data_i = 0; bus_ack_i = 0; bus_rdata_i = 0;
   endtask

   task automatic load(input logic [31:0] a, input logic [2:0] sel, input logic [4:0] rd);
      idle_in();
      dram_rd_en_i = 1; dram_rd_sel_i = sel; addr_i = a;
      rd_wr_en_i = 1; rd_wr_addr_i = rd; rd_wr_sel_i = 2'd1;
   endtask

   initial begin
      idle_in();
      rst_i = 1;
      #1;
      chk("rst_req", 32'(bus_req_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_misal", 32'(misalign_o), 32'd0);
      chk("rst_rden_r", 32'(rd_wr_en_r_o), 32'd0);
      chk("rst_rdata", dram_rd_data_o, 32'd0);
      tick(); tick();
      rst_i = 0;
      tick();

      // ALU op, rd=5
      rd_wr_en_i = 1; rd_wr_addr_i = 5; rd_wr_sel_i = 2'd0;
      #1;
      chk("alu_req", 32'(bus_req_o), 32'd0);
      chk("alu_stall", 32'(stall_o), 32'd0);
      tick();
      chk("alu_en_r", 32'(rd_wr_en_r_o), 32'd1);
      chk("alu_addr_r", 32'(rd_wr_addr_r_o), 32'd5);

      // LW 0x100, ack after 3 stall cycles
      load(32'h100, DRAM_RD_W, 5'd7);
      exp_q.push_back(32'hDEADBEEF);
      #1;
      chk("lw_req", 32'(bus_req_o), 32'd1);
      chk("lw_we", 32'(bus_we_o), 32'd0);
      chk("lw_be", 32'(bus_be_o), 32'hF);
      chk("lw_addr", bus_addr_o, 32'h100);
      stall_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (stall_o) stall_cnt++;
         if (i == 2) begin
            chk("lw_busy_be", 32'(bus_be_o), 32'hF);
            chk("lw_busy_addr", bus_addr_o, 32'h100);
            chk("lw_hold_r", 32'(rd_wr_addr_r_o), 32'd5);
         end
         tick();
      end
      chk("lw_stall_cycles", 32'(stall_cnt), 32'd3);
      bus_ack_i = 1; bus_rdata_i = 32'hDEADBEEF;
      #1;
      chk("lw_ack_stall", 32'(stall_o), 32'd0);
      tick();
      idle_in();
      exp_v = exp_q.pop_front();
      chk("lw_data", dram_rd_data_o, exp_v);
      chk("lw_addr_r", 32'(rd_wr_addr_r_o), 32'd7);
      #1;
      chk("lw_done_req", 32'(bus_req_o), 32'd0);

      // LB 0x103, ack same cycle
      load(32'h103, DRAM_RD_B, 5'd3);
      bus_ack_i = 1; bus_rdata_i = 32'h80112233;
      exp_q.push_back(32'h00000080);
      #1;
      chk("lb_stall", 32'(stall_o), 32'd0);
      chk("lb_be", 32'(bus_be_o), 32'b1000);
      tick();
      idle_in();
      exp_v = exp_q.pop_front();
      chk("lb_data", dram_rd_data_o, exp_v);
      chk("lb_sel_r", 32'(dram_rd_sel_r_o), 32'(DRAM_RD_B));

      // SH 0x102
      dram_wr_en_i = 1; dram_wr_sel_i = 2'd1; addr_i = 32'h102; wr_data_i = 32'h0000ABCD;
      #1;
      chk("sh_we", 32'(bus_we_o), 32'd1);
      chk("sh_be", 32'(bus_be_o), 32'b1100);
      chk("sh_wdata", bus_wdata_o, 32'hABCDABCD);
      chk("sh_addr", bus_addr_o, 32'h100);
      tick();
      chk("sh_busy_wdata", bus_wdata_o, 32'hABCDABCD);
      bus_ack_i = 1;
      tick();
      idle_in();
      chk("sh_rdata_hold", dram_rd_data_o, 32'h00000080);

      // SB 0x101 with both enables high -> store
      dram_rd_en_i = 1; dram_wr_en_i = 1; dram_wr_sel_i = 2'd0;
      addr_i = 32'h101; wr_data_i = 32'h1234565A; bus_ack_i = 1;
      #1;
      chk("sb_we", 32'(bus_we_o), 32'd1);
      chk("sb_be", 32'(bus_be_o), 32'b0010);
      chk("sb_wdata", bus_wdata_o, 32'h5A5A5A5A);
      tick();
      idle_in();

      // reset in BUSY
      load(32'h200, DRAM_RD_W, 5'd9);
      tick();
      chk("rb_busy_stall", 32'(stall_o), 32'd1);
      rst_i = 1;
      #1;
      chk("rb_req", 32'(bus_req_o), 32'd0);
      chk("rb_stall", 32'(stall_o), 32'd0);
      chk("rb_en_r", 32'(rd_wr_en_r_o), 32'd0);
      chk("rb_rdata", dram_rd_data_o, 32'd0);
      idle_in();
      tick();
      rst_i = 0;
      tick();
      bus_ack_i = 1; bus_rdata_i = 32'hFFFFFFFF;
      #1;
      chk("rb_late_req", 32'(bus_req_o), 32'd0);
      tick();
      bus_ack_i = 0;
      chk("rb_late_data", dram_rd_data_o, 32'd0);
      chk("rb_late_stall", 32'(stall_o), 32'd0);

      // misaligned LW 0x101
      load(32'h101, DRAM_RD_W, 5'd4);
`ifdef LSU_MISALIGN_TRAP_EN
      #1;
      chk("mis_req", 32'(bus_req_o), 32'd0);
      chk("mis_stall", 32'(stall_o), 32'd0);
      tick();
      idle_in();
      chk("mis_pulse", 32'(misalign_o), 32'd1);
      chk("mis_en_r", 32'(rd_wr_en_r_o), 32'd0);
      #1;
      chk("mis_req2", 32'(bus_req_o), 32'd0);
      tick();
      chk("mis_pulse_end", 32'(misalign_o), 32'd0);
`else
      bus_ack_i = 1; bus_rdata_i = 32'h11223344;
      exp_q.push_back(32'h11223344);
      #1;
      chk("mis_req", 32'(bus_req_o), 32'd1);
      chk("mis_be", 32'(bus_be_o), 32'hF);
      chk("mis_addr", bus_addr_o, 32'h100);
      tick();
      idle_in();
      exp_v = exp_q.pop_front();
      chk("mis_data", dram_rd_data_o, exp_v);
      chk("mis_pulse", 32'(misalign_o), 32'd0);

      // LH 0x103 masked to half lane 2
      load(32'h103, DRAM_RD_H, 5'd6);
      bus_ack_i = 1; bus_rdata_i = 32'hAABBCCDD;
      exp_q.push_back(32'h0000AABB);
      #1;
      chk("lh_be", 32'(bus_be_o), 32'b1100);
      tick();
      idle_in();
      exp_v = exp_q.pop_front();
      chk("lh_data", dram_rd_data_o, exp_v);
`endif

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
